// File: rtl/shape_streamer_pkg.sv
// Shared defaults, shape/state encodings and the shape drawing rules used by
// the shape streamer and its ROM.
package shape_streamer_pkg;

  localparam int SIZE_DEF     = 25;
  localparam int NSHAPES_DEF  = 3;
  localparam int MAXSCALE_DEF = 4;
  localparam int RING_INSET   = 4;

  typedef enum int {
    SHAPE_BLANK = 0,
    SHAPE_X     = 1,
    SHAPE_O     = 2
  } shape_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FETCH  = 2'd1;
  localparam state_t ST_STREAM = 2'd2;

  // True where the glyph has ink; rows count from the top, columns from the left.
  function automatic logic is_stroke(input int shape, input int size, input int r, input int c);
    int   lo;
    int   hi;
    logic in_box;
    logic in_band;
    logic corner;
    lo = RING_INSET;
    hi = size - 1 - RING_INSET;
    case (shape)
      SHAPE_X: return (c == r) || (c == r + 1) || (c == size - 1 - r) || (c == size - 2 - r);
      SHAPE_O: begin
        in_box  = (r >= lo) && (r <= hi) && (c >= lo) && (c <= hi);
        in_band = (r <= lo + 1) || (r >= hi - 1) || (c <= lo + 1) || (c >= hi - 1);
        corner  = ((r == lo) || (r == hi)) && ((c == lo) || (c == hi));
        return in_box && in_band && !corner;
      end
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shape_streamer_rom.sv
// Combinational shape ROM: one SIZE-bit row per (shape, row); MSB is the
// leftmost column and a stored 0 marks a stroke pixel.
module shape_rom
  import shape_streamer_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int NSHAPES = NSHAPES_DEF,
  parameter int SHW     = 2,
  parameter int RW      = 5
) (
  input  logic [SHW-1:0]  shape,
  input  logic [RW-1:0]   row,
  output logic [SIZE-1:0] row_bits
);

  for (genvar c = 0; c < SIZE; c++) begin : g_col
    assign row_bits[SIZE-1-c] = (int'(shape) < NSHAPES)
                              ? ~is_stroke(int'(shape), SIZE, int'(row), c)
                              : 1'b1;
  end

endmodule

// File: rtl/shape_streamer.sv
// Streams a scaled bitmap glyph as a valid/ready pixel stream in raster order,
// fetching one source row into a row register ahead of its replicated lines.
module shape_streamer
  import shape_streamer_pkg::*;
#(
  parameter  int SIZE     = SIZE_DEF,
  parameter  int NSHAPES  = NSHAPES_DEF,
  parameter  int MAXSCALE = MAXSCALE_DEF,
  localparam int SHW      = (NSHAPES > 1) ? $clog2(NSHAPES) : 1,
  localparam int SW       = $clog2(MAXSCALE) + 1,
  localparam int XW       = $clog2(SIZE * MAXSCALE),
  localparam int CW       = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [SHW-1:0] shape_sel,
  input  logic [SW-1:0]  scale,
  input  logic           invert,
  output logic           busy,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic           pix_data,
  output logic [XW-1:0]  pix_x,
  output logic [XW-1:0]  pix_y,
  output logic           eol,
  output logic           eof
);

  state_t          state;
  logic [SHW-1:0]  cap_shape;
  logic [SW-1:0]   cap_scale;
  logic            cap_invert;
  logic [SIZE-1:0] row_reg;
  logic [SIZE-1:0] rom_bits;
  logic [CW-1:0]   col;
  logic [CW-1:0]   row;
  logic [SW-1:0]   col_sub;
  logic [SW-1:0]   row_sub;
  logic [XW-1:0]   x_cnt;
  logic [XW-1:0]   y_cnt;

  logic [SW-1:0]   eff_scale;
  logic [SHW-1:0]  eff_shape;
  logic            last_col_sub;
  logic            last_row_sub;
  logic            last_col;
  logic            last_row;

  shape_rom #(
    .SIZE    (SIZE),
    .NSHAPES (NSHAPES),
    .SHW     (SHW),
    .RW      (CW)
  ) u_rom (
    .shape    (cap_shape),
    .row      (row),
    .row_bits (rom_bits)
  );

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    eff_scale = scale;
    if (scale == '0) begin
      eff_scale = SW'(1);
    end else if (int'(scale) > MAXSCALE) begin
      eff_scale = SW'(MAXSCALE);
    end
  end

  assign eff_shape    = (int'(shape_sel) < NSHAPES) ? shape_sel : '0;
  assign last_col_sub = (col_sub == cap_scale - SW'(1));
  assign last_row_sub = (row_sub == cap_scale - SW'(1));
  assign last_col     = (col == CW'(SIZE - 1));
  assign last_row     = (row == CW'(SIZE - 1));

  assign busy      = (state != ST_IDLE);
  assign pix_valid = (state == ST_STREAM);
  assign pix_data  = pix_valid & (~row_reg[CW'(SIZE - 1) - col] ^ cap_invert);
  assign pix_x     = x_cnt;
  assign pix_y     = y_cnt;
  assign eol       = pix_valid & last_col & last_col_sub;
  assign eof       = eol & last_row & last_row_sub;

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cap_shape  <= '0;
      cap_scale  <= '0;
      cap_invert <= 1'b0;
      row_reg    <= '0;
      col        <= '0;
      row        <= '0;
      col_sub    <= '0;
      row_sub    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cap_shape  <= eff_shape;
            cap_scale  <= eff_scale;
            cap_invert <= invert;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          row_reg <= rom_bits;
          state   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (pix_ready) begin
            if (!last_col_sub) begin
              col_sub <= col_sub + SW'(1);
              x_cnt   <= x_cnt + XW'(1);
            end else if (!last_col) begin
              col_sub <= '0;
              col     <= col + CW'(1);
              x_cnt   <= x_cnt + XW'(1);
            end else begin
              col_sub <= '0;
              col     <= '0;
              x_cnt   <= '0;
              if (!last_row_sub) begin
                row_sub <= row_sub + SW'(1);
                y_cnt   <= y_cnt + XW'(1);
              end else begin
                row_sub <= '0;
                // A new source row needs one FETCH cycle; the last row ends the frame.
                if (!last_row) begin
                  row   <= row + CW'(1);
                  y_cnt <= y_cnt + XW'(1);
                  state <= ST_FETCH;
                end else begin
                  row   <= '0;
                  y_cnt <= '0;
                  state <= ST_IDLE;
                end
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_streamer.sv
// Self-checking bench for shape_streamer: a pixel-level model of each frame is
// compared beat by beat against the DUT stream under random back-pressure.
module tb_shape_streamer;

  localparam int SIZE = 25;
  localparam int NSH  = 3;
  localparam int MAXS = 4;
  localparam int WMAX = SIZE * MAXS;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [1:0] shape_sel;
  logic [2:0] scale;
  logic       invert;
  logic       busy;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_data;
  logic [6:0] pix_x;
  logic [6:0] pix_y;
  logic       eol;
  logic       eof;

  shape_streamer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .shape_sel (shape_sel),
    .scale     (scale),
    .invert    (invert),
    .busy      (busy),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .eol       (eol),
    .eof       (eof)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_pct = 100;

  logic [16:0] exp_q[$];
  int          beats;
  int          bubbles;
  bit          seen_first;
  int          first_cyc;
  int          start_cyc;
  logic [13:0] eof_xy;
  bit          img[WMAX][WMAX];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = ($urandom_range(99) < ready_pct);
    end
  end

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_scale(input int s);
    if (s == 0) return 1;
    if (s > MAXS) return MAXS;
    return s;
  endfunction

  // Glyph geometry: X = two 2-px diagonals; O = 2-px ring inset 4 with the outer corner pixels cut.
  function automatic bit model_stroke(input int shp, input int r, input int c);
    int lo;
    int hi;
    int dr;
    int dc;
    lo = 4;
    hi = SIZE - 5;
    if (shp == 1) begin
      return (c - r == 0) || (c - r == 1) || (c + r - (SIZE - 1) == 0) || (c + r - (SIZE - 1) == -1);
    end else if (shp == 2) begin
      dr = (r - lo < hi - r) ? r - lo : hi - r;
      dc = (c - lo < hi - c) ? c - lo : hi - c;
      return (dr >= 0) && (dc >= 0) && ((dr <= 1) || (dc <= 1)) && !((dr == 0) && (dc == 0));
    end
    return 1'b0;
  endfunction

  task automatic build_model(input int shp, input int scl, input bit inv, output int total);
    int s;
    int w;
    int sh;
    bit d;
    s  = eff_scale(scl);
    w  = SIZE * s;
    sh = (shp >= NSH) ? 0 : shp;
    exp_q.delete();
    for (int y = 0; y < w; y++) begin
      for (int x = 0; x < w; x++) begin
        d = model_stroke(sh, y / s, x / s) ^ inv;
        exp_q.push_back({d, 7'(x), 7'(y), (x == w - 1), (x == w - 1) && (y == w - 1)});
      end
    end
    total = w * w;
  endtask

  // Compare process: every cycle a beat is offered it must match the model head.
  initial begin
    bit          prev_stall;
    logic [15:0] prev_out;
    logic [16:0] act;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        act = {pix_data, pix_x, pix_y, eol, eof};
        if (prev_stall) begin
          check("stall_hold", {pix_valid, act} == {1'b1, prev_out, eof}, {pix_valid, act}, {1'b1, prev_out, eof});
        end
        if (pix_valid) begin
          if (!seen_first) begin
            seen_first = 1'b1;
            first_cyc  = cyc;
          end
          check("no_extra_beat", exp_q.size() != 0, 0, 1);
          if (exp_q.size() != 0) begin
            check("beat", act == exp_q[0], act, exp_q[0]);
            if (pix_ready) begin
              void'(exp_q.pop_front());
              beats++;
              img[pix_y][pix_x] = pix_data;
              if (eof) eof_xy = {pix_x, pix_y};
            end
          end
        end else if (busy && seen_first) begin
          bubbles++;
        end
        prev_stall = pix_valid && !pix_ready;
        prev_out   = act[16:1];
      end
    end
  end

  task automatic start_frame(input int shp, input int scl, input bit inv, output int total);
    @(posedge clk);
    #1;
    build_model(shp, scl, inv, total);
    beats      = 0;
    bubbles    = 0;
    seen_first = 1'b0;
    eof_xy     = '0;
    img        = '{default: 1'b0};
    start_cyc  = cyc;
    shape_sel  = 2'(shp);
    scale      = 3'(scl);
    invert     = inv;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    shape_sel  = 2'($urandom);
    scale      = 3'($urandom);
    invert     = 1'($urandom);
  endtask

  task automatic wait_beats(input int n);
    int budget;
    budget = 4 * n + 200;
    while (beats < n && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("beat_wait_timeout", budget > 0, budget, 1);
  endtask

  task automatic wait_frame(input string name, input int total);
    int budget;
    budget = 4 * total + 200;
    while ((exp_q.size() != 0 || busy) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check({name, "_timeout"}, budget > 0, budget, 1);
    check({name, "_beats"}, beats == total, beats, total);
    check({name, "_latency"}, first_cyc - start_cyc == 2, first_cyc - start_cyc, 2);
    check({name, "_bubbles"}, bubbles == SIZE - 1, bubbles, SIZE - 1);
    repeat (5) @(posedge clk);
    #1;
    check({name, "_idle_busy"}, {busy, pix_valid} == 2'b00, {busy, pix_valid}, 0);
  endtask

  initial begin
    int total;
    int ones;
    int shp;
    int scl;
    reset_n   = 1'b0;
    start     = 1'b0;
    shape_sel = '0;
    scale     = '0;
    invert    = 1'b0;
    #3;
    check("reset_outputs", {busy, pix_valid, pix_data, pix_x, pix_y, eol, eof} == '0,
          {busy, pix_valid, pix_data, pix_x, pix_y, eol, eof}, 0);
    #19;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", {busy, pix_valid} == 2'b00, {busy, pix_valid}, 0);

    // Ring at scale 1, always ready.
    start_frame(2, 1, 1'b0, total);
    wait_frame("ring_s1", total);
    check("ring_total_625", total == 625, total, 625);
    check("ring_px00", img[0][0] == 1'b0, img[0][0], 0);
    check("ring_px_top", img[4][12] == 1'b1, img[4][12], 1);
    check("ring_px_center", img[12][12] == 1'b0, img[12][12], 0);
    check("ring_eof_xy", eof_xy == {7'd24, 7'd24}, eof_xy, {7'd24, 7'd24});

    // X at scale 2.
    start_frame(1, 2, 1'b0, total);
    wait_frame("x_s2", total);
    check("x_total_2500", total == 2500, total, 2500);
    check("x_px_0_0", img[0][0] == 1'b1, img[0][0], 1);
    check("x_px_1_1", img[1][1] == 1'b1, img[1][1], 1);
    check("x_px_49_0", img[0][49] == 1'b1, img[0][49], 1);
    check("x_px_25_0", img[0][25] == 1'b0, img[0][25], 0);
    check("x_eof_xy", eof_xy == {7'd49, 7'd49}, eof_xy, {7'd49, 7'd49});

    // Blank, inverted, scale 0 behaves as scale 1.
    start_frame(0, 0, 1'b1, total);
    wait_frame("blank_inv", total);
    ones = 0;
    for (int y = 0; y < SIZE; y++)
      for (int x = 0; x < SIZE; x++)
        ones += int'(img[y][x]);
    check("blank_inv_ones", ones == 625, ones, 625);

    // Same ring frame under 50% back-pressure.
    ready_pct = 50;
    start_frame(2, 1, 1'b0, total);
    wait_frame("ring_stall", total);
    ready_pct = 100;

    // Reset pulse mid-frame abandons it.
    start_frame(2, 1, 1'b0, total);
    wait_beats(300);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_outputs", {busy, pix_valid, pix_data, pix_x, pix_y, eol, eof} == '0,
          {busy, pix_valid, pix_data, pix_x, pix_y, eol, eof}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("reset_abandon_busy", {busy, pix_valid} == 2'b00, {busy, pix_valid}, 0);
    start_frame(2, 1, 1'b0, total);
    wait_frame("after_reset", total);

    // Start and shape change while busy are ignored.
    start_frame(1, 1, 1'b0, total);
    wait_beats(100);
    start     = 1'b1;
    shape_sel = 2'd2;
    scale     = 3'd3;
    invert    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_frame("busy_start", total);
    repeat (10) @(posedge clk);
    #1;
    check("no_second_frame", busy == 1'b0, busy, 0);

    // Random frames, including out-of-range shape and scale codes.
    ready_pct = 70;
    for (int i = 0; i < 3; i++) begin
      shp = $urandom_range(3);
      scl = $urandom_range(7);
      start_frame(shp, scl, 1'($urandom), total);
      wait_frame($sformatf("rand%0d", i), total);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shape_streamer.md
SHAPE_STREAMER -- requirements
Module: shape_streamer

Interface
REQ-001 Parameter SIZE, default 25, square bitmap edge in pixels.
REQ-002 Parameter NSHAPES, default 3, number of stored shapes (0 = blank, 1 = X, 2 = O).
REQ-003 Parameter MAXSCALE, default 4, largest pixel-replication factor.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request a frame; sampled only in IDLE.
REQ-007 shape_sel  input  clog2(NSHAPES)  shape index, captured on accepted start.
REQ-008 scale  input  clog2(MAXSCALE)+1  replication factor, captured on accepted start.
REQ-009 invert  input  1  swap foreground/background polarity, captured on accepted start.
REQ-010 busy  output  1  high from accepted start until the last pixel is accepted.
REQ-011 pix_valid  output  1  pixel beat valid.
REQ-012 pix_ready  input  1  downstream accepts the beat.
REQ-013 pix_data  output  1  1 = stroke, 0 = background (after invert).
REQ-014 pix_x, pix_y  output  clog2(SIZE*MAXSCALE) each  scaled coordinate of the current beat.
REQ-015 eol  output  1  current beat is the last of a line; eof  output  1  current beat is the last of the frame.

Function
REQ-016 Shape ROM: NSHAPES x SIZE rows of SIZE bits; row 0 = top; MSB = leftmost column; stored bit 0 = stroke, 1 = background.
REQ-017 Shape 0 is all-background; shape 1 is two full diagonals, 2 px wide; shape 2 is a ring, 2 px wide, inset 4 columns from each side, with rounded corners.
REQ-018 FSM states IDLE, FETCH, STREAM; IDLE->FETCH on start; FETCH->STREAM after one cycle; STREAM->FETCH at end of a source row's last replicated line; STREAM->IDLE on eof beat accepted.
REQ-019 scale value 0 is treated as 1; values > MAXSCALE are clamped to MAXSCALE.
REQ-020 Frame is W x W beats, W = SIZE x effective scale; raster order, x fastest.
REQ-021 pix_data for (pix_x, pix_y) = NOT ROM[shape][pix_y/scale][bit SIZE-1-pix_x/scale], XOR invert.
REQ-022 FETCH loads one ROM row into a SIZE-bit row register; pix_valid is 0 in IDLE and FETCH.
REQ-023 First pix_valid occurs 2 cycles after the accepted start cycle; each later source row costs exactly one FETCH bubble cycle.
REQ-024 In STREAM, pix_valid stays high and pix_data, pix_x, pix_y, eol, eof hold stable while pix_ready is low.
REQ-025 Beat advances only when pix_valid and pix_ready are both high.
REQ-026 shape_sel >= NSHAPES selects shape 0.
REQ-027 start while busy is ignored; inputs changing while busy do not affect the frame in progress.
REQ-028 eol high when pix_x = W-1; eof high when pix_x = W-1 and pix_y = W-1.
REQ-029 Counters: column counter, column sub-scale counter, row counter, row sub-scale counter; all wrap to 0 at their terminal counts without overflow into unused codes.

Reset
REQ-030 reset_n low forces IDLE immediately, regardless of clock; all outputs 0 (busy, pix_valid, pix_data, pix_x, pix_y, eol, eof).
REQ-031 Reset mid-frame abandons the frame; no beat is emitted after reset release until a new start is accepted.
REQ-032 Captured shape/scale/invert registers and row register reset to 0.

Structure
REQ-033 Shared package holds SIZE, NSHAPES, MAXSCALE defaults, the shape-index enumeration, and the FSM state typedef.
REQ-034 One sub-module, shape_rom: combinational ROM indexed by shape and row, returning one SIZE-bit row; the streamer registers its output.

Verification
REQ-035 start, shape 2, scale 1, pix_ready held 1 -> 625 beats, first beat 2 cycles after start, 24 single-cycle bubbles, eof on beat (24,24), pix_data(0,0)=0.
REQ-036 shape 1, scale 2 -> 2500 beats; pix_data at (0,0),(1,1),(49,0) = 1; (25,0) = 0; row register refetched every 2 lines.
REQ-037 shape 0, invert 1, scale 0 -> 625 beats, all pix_data = 1, effective scale 1.
REQ-038 Random pix_ready with 50% duty -> beat sequence identical to ready-always run; outputs stable across every stall cycle.
REQ-039 reset_n pulsed low for 1 cycle at beat 300 -> outputs 0 asynchronously, busy 0; next start produces a complete, correct frame.
REQ-040 start reasserted and shape_sel changed mid-frame -> ignored; frame completes with the original shape, no second frame starts.
